// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM state codes,
// opcodes handled by the controller and the mux/ALU select encodings.
package mips_pkg;

  // FSM states; codes 12-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Opcodes (instruction[31:26]) understood by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // alu_op codes handed to the ALU control stage
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // True for every opcode that DECODE can dispatch on
  function automatic logic is_legal_opcode(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// State-to-control-signal decode for the multicycle MIPS controller.
// Purely combinational; the only non-state inputs are mem_ready (FETCH
// write strobes), zero (branch PC enable), opcode (illegal flag in DECODE)
// and rst_n (forces all write enables low while reset is held).
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  input  logic        rst_n,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_en,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic        illegal_op,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_op
);

  // Per-state control outputs, then PC enable, then reset gating of writes
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_en         = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    illegal_op    = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_src        = PC_SRC_ALU;
    alu_op        = ALU_ADD;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        illegal_op = !is_legal_opcode(opcode);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_src        = PC_SRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
      end
      default: begin
      end
    endcase

    pc_en = pc_write | (pc_write_cond & zero);

    if (!rst_n) begin
      pc_write   = 1'b0;
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: state register and next-state logic,
// with the per-state output decode delegated to mips_ctrl_decode.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_en,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic        illegal_op,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_op,
  output logic [3:0]  state
);

  state_t state_q;
  state_t state_d;

  // State register; reset is synchronous and wins over any wait state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; memory states stall until mem_ready
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

  mips_ctrl_decode u_decode (
    .state         (state_q),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_en         (pc_en),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .illegal_op    (illegal_op),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .alu_op        (alu_op)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for the multicycle MIPS controller. Each instruction is modelled as
// the list of states it walks through (with memory waits inserted), and each
// state has a fixed table of expected control outputs.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       illegal_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
  } ctl_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_ADDI = 3, C_BEQ = 4, C_J = 5, C_ILL = 6;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  mips_multicycle_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_en         (pc_en),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .illegal_op    (illegal_op),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .alu_op        (alu_op),
    .state         (state)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected controls for a state, written straight from the per-state rules
  function automatic ctl_t expected_ctl(int st, bit mr, bit z, bit rn, bit ill);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.pc_write = mr; c.ir_write = mr; end
      1:  begin c.alu_src_b = 2'b11; c.illegal_op = ill; end
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.i_or_d = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.i_or_d = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_write_cond = 1; end
      9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      10: begin c.reg_write = 1; end
      11: begin c.pc_src = 2'b10; c.pc_write = 1; end
      default: c = '0;
    endcase
    c.pc_en = c.pc_write | (c.pc_write_cond & z);
    if (!rn) begin
      c.pc_write = 0; c.pc_en = 0; c.ir_write = 0;
      c.mem_write = 0; c.reg_write = 0; c.illegal_op = 0;
    end
    return c;
  endfunction

  // Drive this cycle's inputs and let the outputs settle until the falling edge
  task automatic applyStimulus(logic [5:0] op, bit z, bit mr, bit rn);
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    rst_n     = rn;
    @(negedge clk);
  endtask

  // Compare the DUT state and full control vector against expectations
  task automatic checkOutput(int exp_st, ctl_t exp_c, string tag);
    ctl_t obs;
    obs = '{pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, alu_src_b, pc_src, alu_op};
    vectors++;
    assert (state === 4'(exp_st)) else begin
      miscompares++;
      $error("[TB] FAIL %s.state observed=%0d expected=%0d", tag, state, exp_st);
    end
    vectors++;
    assert (obs === exp_c) else begin
      miscompares++;
      $error("[TB] FAIL %s.ctl(st%0d) observed=%05h expected=%05h", tag, exp_st, obs, exp_c);
    end
  endtask

  // One clock cycle: apply inputs, check, advance to just after the next rising edge
  task automatic step(int exp_st, logic [5:0] op, bit z, bit mr, bit rn, bit ill, string tag);
    applyStimulus(op, z, mr, rn);
    checkOutput(exp_st, expected_ctl(exp_st, mr, z, rn, ill), tag);
    @(posedge clk);
    #1;
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] opcode_for(int cls);
    logic [5:0] op;
    case (cls)
      C_LW:   op = 6'b100011;
      C_SW:   op = 6'b101011;
      C_R:    op = 6'b000000;
      C_ADDI: op = 6'b001000;
      C_BEQ:  op = 6'b000100;
      C_J:    op = 6'b000010;
      default: begin
        do op = 6'($urandom_range(0, 63));
        while (op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b001000 || op == 6'b000100 || op == 6'b000010);
      end
    endcase
    return op;
  endfunction

  // Walk one whole instruction: fetch (with fw stalls), decode, then the
  // class-specific tail; memory stages stall mw cycles before completing
  task automatic runInstr(int cls, logic [5:0] op, int fw, int mw, bit bz, string tag);
    for (int i = 0; i < fw; i++) step(0, op, rbit(), 1'b0, 1'b1, 1'b0, tag);
    step(0, op, rbit(), 1'b1, 1'b1, 1'b0, tag);
    step(1, op, rbit(), rbit(), 1'b1, cls == C_ILL, tag);
    case (cls)
      C_LW: begin
        step(2, op, rbit(), rbit(), 1'b1, 1'b0, tag);
        for (int i = 0; i < mw; i++) step(3, op, rbit(), 1'b0, 1'b1, 1'b0, tag);
        step(3, op, rbit(), 1'b1, 1'b1, 1'b0, tag);
        step(4, op, rbit(), rbit(), 1'b1, 1'b0, tag);
      end
      C_SW: begin
        step(2, op, rbit(), rbit(), 1'b1, 1'b0, tag);
        for (int i = 0; i < mw; i++) step(5, op, rbit(), 1'b0, 1'b1, 1'b0, tag);
        step(5, op, rbit(), 1'b1, 1'b1, 1'b0, tag);
      end
      C_R: begin
        step(6, op, rbit(), rbit(), 1'b1, 1'b0, tag);
        step(7, op, rbit(), rbit(), 1'b1, 1'b0, tag);
      end
      C_ADDI: begin
        step(9, op, rbit(), rbit(), 1'b1, 1'b0, tag);
        step(10, op, rbit(), rbit(), 1'b1, 1'b0, tag);
      end
      C_BEQ: step(8, op, bz, rbit(), 1'b1, 1'b0, tag);
      C_J:   step(11, op, rbit(), rbit(), 1'b1, 1'b0, tag);
      default: begin
      end
    endcase
  endtask

  // Directed scenarios first, then a randomized instruction stream
  initial begin
    logic [5:0] op;
    int cls;
    rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] power-on reset");
    step(0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, "por");
    step(0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, "por");

    $display("[TB] lw, no stalls");
    runInstr(C_LW, 6'b100011, 0, 0, 1'b0, "lw");

    $display("[TB] reset while stalled in MEMRD");
    step(0, 6'b100011, 1'b0, 1'b1, 1'b1, 1'b0, "rst_mid");
    step(1, 6'b100011, 1'b0, 1'b1, 1'b1, 1'b0, "rst_mid");
    step(2, 6'b100011, 1'b0, 1'b1, 1'b1, 1'b0, "rst_mid");
    step(3, 6'b100011, 1'b0, 1'b0, 1'b1, 1'b0, "rst_mid");
    step(3, 6'b100011, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid");
    step(0, 6'b100011, 1'b1, 1'b1, 1'b0, 1'b0, "rst_mid");

    $display("[TB] beq taken / not taken");
    runInstr(C_BEQ, 6'b000100, 0, 0, 1'b1, "beq_t");
    runInstr(C_BEQ, 6'b000100, 1, 0, 1'b0, "beq_nt");

    $display("[TB] sw stalled 3 cycles");
    runInstr(C_SW, 6'b101011, 0, 3, 1'b0, "sw_wait");

    $display("[TB] illegal opcode 111111");
    runInstr(C_ILL, 6'b111111, 0, 0, 1'b0, "ill");

    runInstr(C_R, 6'b000000, 0, 0, 1'b0, "rtype");
    runInstr(C_ADDI, 6'b001000, 2, 0, 1'b0, "addi");
    runInstr(C_J, 6'b000010, 0, 0, 1'b0, "jump");

    $display("[TB] random instruction stream");
    for (int n = 0; n < 150; n++) begin
      cls = int'($urandom_range(0, 6));
      op  = opcode_for(cls);
      runInstr(cls, op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rbit(), "rand");
    end
    step(0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, "tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
